pd_lp_filter_p: RTL and testbench

- Parametrised successor to the multiplier phase-detector / moving-average low-pass used in the signal-separator PLL loop.
- Multiplies a reference sample by a signal sample and decimates the product stream by DECIM.
- Averages the last 2^TAPS_LOG2 decimated products with a running-sum boxcar filter.
- Drives a hysteretic lock-adjust flag plus the filter sign. Sits between the ADC/NCO sample path and the PLL frequency-control logic.

---
 rtl/pd_lp_filter_p.sv | 173 +++++++++++++++++
 tb/tb_pd_lp_filter_p.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pd_lp_filter_p.sv
// pd_lp_filter_p: multiplier phase detector with a decimated boxcar low-pass filter.
//
// Multiplies the reference sample by the measured sample. The product stream is decimated
// by DECIM. The last 2^TAPS_LOG2 decimated products are averaged with a running-sum boxcar.
// A hysteretic |sum| threshold flag and the sign of the sum are then derived for the
// PLL frequency-control logic.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   sys_rst     synchronous active-high reset
//   in_valid    ref_sig / sig_sig qualify this cycle
//   ref_sig     signed reference sample (IN_W)
//   sig_sig     signed measured sample (IN_W)
//   flush       synchronous clear of delay line and sum (lower priority than sys_rst)
//   sum_out     signed running sum of the window (2*IN_W+TAPS_LOG2)
//   sum_valid   sum_out covers a full window
//   adjust      hysteretic |sum| threshold flag
//   adjust_neg  sign of sum_out while sum_valid, else 0
//
// Latency: a pushing sample taken at edge t appears on sum_out at edge t+2, and it affects
// adjust/adjust_neg at edge t+3.

module pd_lp_filter_p #(
    parameter int unsigned IN_W      = 10,
    parameter int unsigned TAPS_LOG2 = 5,
    parameter int unsigned DECIM     = 2,
    parameter logic [31:0] THOLD_HI  = 32'h00FF_1111,
    parameter logic [31:0] THOLD_LO  = 32'h00F0_0000
) (
    input  logic                                 clk,
    input  logic                                 sys_rst,
    input  logic                                 in_valid,
    input  logic signed [IN_W-1:0]               ref_sig,
    input  logic signed [IN_W-1:0]               sig_sig,
    input  logic                                 flush,
    output logic signed [2*IN_W+TAPS_LOG2-1:0]   sum_out,
    output logic                                 sum_valid,
    output logic                                 adjust,
    output logic                                 adjust_neg
);

    localparam int unsigned ProdW  = 2 * IN_W;
    localparam int unsigned AccW   = 2 * IN_W + TAPS_LOG2;
    localparam int unsigned Depth  = 1 << TAPS_LOG2;
    localparam int unsigned CmpW   = (AccW + 1 > 32) ? AccW + 1 : 32;
    localparam int unsigned DcntW  = 5;

    localparam logic [DcntW-1:0]     DcntLast = DcntW'(DECIM - 1);
    localparam logic [TAPS_LOG2-1:0] FillLast = TAPS_LOG2'(Depth - 1);
    localparam logic [CmpW-1:0]      HiCmp    = CmpW'(THOLD_HI);
    localparam logic [CmpW-1:0]      LoCmp    = CmpW'(THOLD_LO);

    typedef enum logic [0:0] {StFill, StRun} state_e;

    // ------------------------------------------------------------------
    // S1: product and decimation
    // ------------------------------------------------------------------
    logic signed [ProdW-1:0] ref_ext, sig_ext, prod_d, prod_q;
    logic [DcntW-1:0]        dcnt_q;
    logic                    push_q;

    assign ref_ext = $signed({{IN_W{ref_sig[IN_W-1]}}, ref_sig});
    assign sig_ext = $signed({{IN_W{sig_sig[IN_W-1]}}, sig_sig});
    assign prod_d  = ref_ext * sig_ext;

    always_ff @(posedge clk) begin
        if (sys_rst || flush) begin
            // A sample arriving together with flush is dropped.
            dcnt_q <= '0;
            push_q <= 1'b0;
            prod_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (in_valid) begin
                prod_q <= prod_d;
                if (dcnt_q == DcntLast) begin
                    dcnt_q <= '0;
                    push_q <= 1'b1;
                end else begin
                    dcnt_q <= dcnt_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: delay line, running sum and fill state machine
    // ------------------------------------------------------------------
    logic signed [ProdW-1:0] line_q [Depth];
    logic [TAPS_LOG2-1:0]    wptr_q;
    logic [TAPS_LOG2-1:0]    fill_cnt_q;
    logic signed [AccW-1:0]  sum_q, sum_d;
    logic                    valid_q;
    state_e                  state_q;
    logic signed [ProdW-1:0] oldest;

    always_comb begin
        // While filling, the slot being overwritten has never held a product.
        oldest = (state_q == StFill) ? '0 : line_q[wptr_q];
        sum_d  = sum_q
               + $signed({{TAPS_LOG2{prod_q[ProdW-1]}}, prod_q})
               - $signed({{TAPS_LOG2{oldest[ProdW-1]}}, oldest});
    end

    always_ff @(posedge clk) begin
        if (sys_rst || flush) begin
            for (int i = 0; i < Depth; i++) begin
                line_q[i] <= '0;
            end
            wptr_q     <= '0;
            fill_cnt_q <= '0;
            sum_q      <= '0;
            valid_q    <= 1'b0;
            state_q    <= StFill;
            sum_out    <= '0;
            sum_valid  <= 1'b0;
        end else begin
            // Output register: keeps sum_out and sum_valid aligned with each other.
            sum_out   <= sum_q;
            sum_valid <= valid_q;
            if (push_q) begin
                line_q[wptr_q] <= prod_q;
                wptr_q         <= wptr_q + 1'b1;
                sum_q          <= sum_d;
                unique case (state_q)
                    StFill: begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                        if (fill_cnt_q == FillLast) begin
                            state_q <= StRun;
                            valid_q <= 1'b1;
                        end
                    end
                    StRun: begin
                        state_q <= StRun;
                    end
                    default: begin
                        state_q <= StFill;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: hysteretic threshold decision
    // ------------------------------------------------------------------
    logic [AccW:0]   sum_wide;
    logic [AccW:0]   abs_sum;
    logic [CmpW-1:0] abs_cmp;

    // One extra bit so that the most-negative sum has an exact magnitude.
    assign sum_wide = {sum_out[AccW-1], sum_out};
    assign abs_sum  = sum_out[AccW-1] ? (~sum_wide + 1'b1) : sum_wide;
    assign abs_cmp  = CmpW'(abs_sum);

    always_ff @(posedge clk) begin
        if (sys_rst || flush) begin
            adjust     <= 1'b0;
            adjust_neg <= 1'b0;
        end else if (!sum_valid) begin
            adjust     <= 1'b0;
            adjust_neg <= 1'b0;
        end else begin
            adjust_neg <= sum_out[AccW-1];
            if (abs_cmp >= HiCmp) begin
                adjust <= 1'b1;
            end else if (abs_cmp < LoCmp) begin
                adjust <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pd_lp_filter_p.sv
module tb_pd_lp_filter_p;

    localparam int AccW   = 22;
    localparam int NB     = 4;
    localparam int DecimB = 4;
    localparam longint HiB = 400;
    localparam longint LoB = 100;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;

    // DUT A: DECIM=1, N=4, HI=400, LO=300
    logic                   a_valid = 1'b0, a_flush = 1'b0;
    logic signed [9:0]      a_ref = '0, a_sig = '0;
    logic signed [AccW-1:0] a_sum_out;
    logic                   a_sum_valid, a_adjust, a_adjust_neg;

    // DUT B: DECIM=4, N=4, HI=400, LO=100
    logic                   b_valid = 1'b0, b_flush = 1'b0;
    logic signed [9:0]      b_ref = '0, b_sig = '0;
    logic signed [AccW-1:0] b_sum_out;
    logic                   b_sum_valid, b_adjust, b_adjust_neg;

    pd_lp_filter_p #(
        .IN_W(10), .TAPS_LOG2(2), .DECIM(1), .THOLD_HI(32'd400), .THOLD_LO(32'd300)
    ) u_dut_a (
        .clk(clk), .sys_rst(sys_rst), .in_valid(a_valid), .ref_sig(a_ref), .sig_sig(a_sig),
        .flush(a_flush), .sum_out(a_sum_out), .sum_valid(a_sum_valid), .adjust(a_adjust),
        .adjust_neg(a_adjust_neg)
    );

    pd_lp_filter_p #(
        .IN_W(10), .TAPS_LOG2(2), .DECIM(4), .THOLD_HI(32'd400), .THOLD_LO(32'd100)
    ) u_dut_b (
        .clk(clk), .sys_rst(sys_rst), .in_valid(b_valid), .ref_sig(b_ref), .sig_sig(b_sig),
        .flush(b_flush), .sum_out(b_sum_out), .sum_valid(b_sum_valid), .adjust(b_adjust),
        .adjust_neg(b_adjust_neg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model for DUT B: a window of the last N decimated products, summed
    // arithmetically, with the observable pipeline delays applied around it.
    longint win[$];
    bit     pend = 0;
    longint pend_v = 0;
    int     dcnt = 0;
    longint m_sum = 0;
    bit     m_valid = 0, m_adj = 0, m_neg = 0;

    task automatic model_step();
        longint s, a;
        if (sys_rst || b_flush) begin
            win.delete();
            pend = 0; dcnt = 0;
            m_sum = 0; m_valid = 0; m_adj = 0; m_neg = 0;
        end else begin
            a = (m_sum < 0) ? -m_sum : m_sum;
            if (!m_valid) begin
                m_adj = 0; m_neg = 0;
            end else begin
                m_neg = (m_sum < 0);
                if (a >= HiB) m_adj = 1;
                else if (a < LoB) m_adj = 0;
            end
            s = 0;
            foreach (win[i]) s += win[i];
            m_sum   = s;
            m_valid = (win.size() == NB);
            if (pend) begin
                win.push_back(pend_v);
                if (win.size() > NB) void'(win.pop_front());
            end
            pend = 0;
            if (b_valid) begin
                if (dcnt == DecimB - 1) begin
                    dcnt   = 0;
                    pend   = 1;
                    pend_v = longint'(b_ref) * longint'(b_sig);
                end else begin
                    dcnt++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("b_model_sum", longint'(b_sum_out), m_sum);
        chk("b_model_valid", longint'(b_sum_valid), longint'(m_valid));
        chk("b_model_adjust", longint'(b_adjust), longint'(m_adj));
        chk("b_model_neg", longint'(b_adjust_neg), longint'(m_neg));
    endtask

    // Four valid samples interleaved with idle cycles, then let the pipeline settle.
    task automatic push_b(input int r, input int s);
        for (int k = 0; k < DecimB; k++) begin
            b_valid = 1'b1; b_ref = 10'(r); b_sig = 10'(s);
            tick();
            b_valid = 1'b0;
            tick();
        end
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic flush_b();
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
    endtask

    typedef struct {
        bit     rst;
        bit     flush;
        bit     vld;
        int     r;
        int     s;
        longint e_sum;
        bit     e_val;
        bit     e_adj;
        bit     e_neg;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Fill, steady window, flush and reset sequences for DUT A.
        for (int i = 0; i < 4; i++) vecs.push_back('{0, 0, 1, 10, 10, 0, 0, 0, 0});
        vecs[2].e_sum = 100;
        vecs[3].e_sum = 200;
        vecs.push_back('{0, 0, 1, 10, -10,  300, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10, -10,  400, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 10, -10,  200, 1, 1, 0});
        vecs.push_back('{0, 0, 1, 10, -10,    0, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 10, -10, -200, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 10, -10, -400, 1, 0, 1});
        vecs.push_back('{0, 0, 1, 10, -10, -400, 1, 1, 1});
        vecs.push_back('{0, 1, 1, 10,  10,    0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10,  10,    0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10,  10,    0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10,  10,  100, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10,  10,  200, 0, 0, 0});
        vecs.push_back('{1, 0, 1, 10,  10,    0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10,  10,    0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10,  10,    0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10,  10,  100, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10,  10,  200, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10,  10,  300, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 10,  10,  400, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 10,  10,  400, 1, 1, 0});

        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        chk("rst_a_sum", longint'(a_sum_out), 0);
        chk("rst_a_valid", longint'(a_sum_valid), 0);
        chk("rst_a_adjust", longint'(a_adjust), 0);
        chk("rst_a_neg", longint'(a_adjust_neg), 0);

        foreach (vecs[i]) begin
            sys_rst = vecs[i].rst;
            a_flush = vecs[i].flush;
            a_valid = vecs[i].vld;
            a_ref   = 10'(vecs[i].r);
            a_sig   = 10'(vecs[i].s);
            tick();
            chk($sformatf("a_sum[%0d]", i), longint'(a_sum_out), vecs[i].e_sum);
            chk($sformatf("a_valid[%0d]", i), longint'(a_sum_valid), longint'(vecs[i].e_val));
            chk($sformatf("a_adjust[%0d]", i), longint'(a_adjust), longint'(vecs[i].e_adj));
            chk($sformatf("a_neg[%0d]", i), longint'(a_adjust_neg), longint'(vecs[i].e_neg));
        end
        sys_rst = 1'b0; a_flush = 1'b0; a_valid = 1'b0;

        // Decimation: three valid samples (with idle gaps) must not push.
        flush_b();
        for (int k = 0; k < 3; k++) begin
            b_valid = 1'b1; b_ref = 10'(10); b_sig = 10'(10);
            tick();
            b_valid = 1'b0;
            tick();
        end
        for (int k = 0; k < 4; k++) tick();
        chk("decim_3_samples", longint'(b_sum_out), 0);
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("decim_4th_sample", longint'(b_sum_out), 100);
        chk("decim_not_full", longint'(b_sum_valid), 0);

        // Hysteresis: 400 -> 300 -> 200 -> 100 -> 50.
        for (int k = 0; k < 3; k++) push_b(10, 10);
        chk("hyst_400_sum", longint'(b_sum_out), 400);
        chk("hyst_400_adj", longint'(b_adjust), 1);
        push_b(0, 0);
        chk("hyst_300_sum", longint'(b_sum_out), 300);
        chk("hyst_300_adj", longint'(b_adjust), 1);
        push_b(0, 0);
        chk("hyst_200_adj", longint'(b_adjust), 1);
        push_b(0, 0);
        chk("hyst_100_sum", longint'(b_sum_out), 100);
        chk("hyst_100_adj", longint'(b_adjust), 1);
        push_b(5, 10);
        chk("hyst_50_sum", longint'(b_sum_out), 50);
        chk("hyst_50_adj", longint'(b_adjust), 0);

        // Extremes.
        flush_b();
        for (int k = 0; k < 4; k++) push_b(-512, -512);
        chk("ext_pos_sum", longint'(b_sum_out), 1048576);
        chk("ext_pos_valid", longint'(b_sum_valid), 1);
        chk("ext_pos_adj", longint'(b_adjust), 1);
        chk("ext_pos_neg", longint'(b_adjust_neg), 0);
        for (int k = 0; k < 4; k++) push_b(-512, 511);
        chk("ext_neg_sum", longint'(b_sum_out), -1046528);
        chk("ext_neg_adj", longint'(b_adjust), 1);
        chk("ext_neg_neg", longint'(b_adjust_neg), 1);

        // Randomized run against the model.
        for (int c = 0; c < 1500; c++) begin
            b_valid = ($urandom_range(0, 3) != 0);
            b_ref   = 10'(int'($urandom_range(0, 24)) - 12);
            b_sig   = 10'(int'($urandom_range(0, 24)) - 12);
            b_flush = ($urandom_range(0, 249) == 0);
            sys_rst = (c == 700);
            tick();
        end
        sys_rst = 1'b0; b_flush = 1'b0; b_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
